online_div_ca_seq_ctrl: RTL and testbench

Sequencer for the online-division digit store that banks q/d signed digits four per RAM word. Per iteration it accepts one digit pair from the digit-selection stage and issues exactly one write to the store. It then sweeps the read address over every word written so far, so the CA/residual datapath can rebuild its operands. It drives the store's master_cnt, wr_enable, enable_all, rd_addr and comp_cycle inputs.

---
 rtl/online_div_pkg.sv | 21 ++
 rtl/online_div_valid_pipe.sv | 29 ++
 rtl/online_div_ca_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_online_div_ca_seq_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/online_div_pkg.sv
// Shared definitions for the online-division digit-store sequencer: state encoding,
// default store geometry and the digit ceiling.
package online_div_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StWaitDig = 3'd1,
        StSweep   = 3'd2,
        StDrain   = 3'd3,
        StDone    = 3'd4
    } state_t;

    localparam int unsigned RAM_ADDR_WIDTH_DEF = 7;
    localparam int unsigned DIGIT_CEIL         = 4 * (2 ** RAM_ADDR_WIDTH_DEF);

    // Four digits are banked per word, so the store holds 4 * 2^aw digits.
    function automatic int unsigned digit_ceil(input int unsigned aw);
        return 4 * (2 ** aw);
    endfunction

endpackage

// File: rtl/online_div_valid_pipe.sv
// DEPTH-deep delay line for the store read-valid strobe; flushed by async_clear.
module online_div_valid_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic async_clear,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr_q;

    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge clk or negedge async_clear) begin
                if (!async_clear) sr_q <= '0;
                else              sr_q <= din;
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge async_clear) begin
                if (!async_clear) sr_q <= '0;
                else              sr_q <= {sr_q[DEPTH-2:0], din};
            end
        end
    endgenerate

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/online_div_ca_seq_ctrl.sv
// Write/read sequencer for the online-division q/d digit store.
// Optional stall_cnt output enabled by defining ONLINE_DIV_STALL_CNT_EN.
module online_div_ca_seq_ctrl
    import online_div_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH = RAM_ADDR_WIDTH_DEF,
    parameter int unsigned N_DIGITS       = 32,
    parameter int unsigned RD_LAT         = 1
) (
    input  logic                      clk,
    input  logic                      async_clear,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      dig_valid,
    output logic                      dig_ready,
    input  logic                      rd_stall,
    output logic [RAM_ADDR_WIDTH+1:0] master_cnt,
    output logic                      wr_enable,
    output logic                      enable_all,
    output logic [RAM_ADDR_WIDTH-1:0] rd_addr,
    output logic [RAM_ADDR_WIDTH-1:0] comp_cycle,
    output logic                      rd_valid,
    output logic                      rd_last,
    output logic                      rd_data_valid,
    output logic                      iter_done,
    output logic                      busy,
    output logic                      done
`ifdef ONLINE_DIV_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    localparam int unsigned MW      = RAM_ADDR_WIDTH + 2;
    localparam int unsigned CNT_MAX = digit_ceil(RAM_ADDR_WIDTH) - 1;

    state_t                    state_q;
    logic [MW-1:0]             cnt_q;
    logic [RAM_ADDR_WIDTH-1:0] rd_addr_q;
    logic [RAM_ADDR_WIDTH-1:0] comp_q;
    logic [1:0]                drain_q;
    logic                      full_q;
    logic                      done_q;
    logic                      drain_end;
    logic                      start_ok;

    always_comb begin
        dig_ready  = (state_q == StWaitDig);
        wr_enable  = dig_ready & dig_valid & ~abort;
        rd_valid   = (state_q == StSweep) & ~rd_stall & ~abort;
        rd_last    = rd_valid & (rd_addr_q == comp_q);
        drain_end  = (state_q == StDrain) && (drain_q == 2'(RD_LAT - 1));
        iter_done  = drain_end & ~abort;
        enable_all = (state_q != StIdle);
        busy       = (state_q == StWaitDig) || (state_q == StSweep) || (state_q == StDrain);
        start_ok   = start && ((state_q == StIdle) || (state_q == StDone));
    end

    assign master_cnt = cnt_q;
    assign rd_addr    = rd_addr_q;
    assign comp_cycle = comp_q;
    assign done       = done_q;

    always_ff @(posedge clk or negedge async_clear) begin
        if (!async_clear) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rd_addr_q <= '0;
            comp_q    <= '0;
            drain_q   <= '0;
            full_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (abort) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rd_addr_q <= '0;
            comp_q    <= '0;
            drain_q   <= '0;
            full_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        cnt_q   <= '0;
                        full_q  <= 1'b0;
                        done_q  <= 1'b0;
                        state_q <= StWaitDig;
                    end
                end
                StWaitDig: begin
                    if (dig_valid) begin
                        // Saturate instead of wrapping when N_DIGITS fills the store.
                        if (32'(cnt_q) < CNT_MAX) cnt_q <= cnt_q + 1'b1;
                        full_q    <= (32'(cnt_q) + 1 == N_DIGITS);
                        comp_q    <= cnt_q[MW-1:2];
                        rd_addr_q <= '0;
                        state_q   <= StSweep;
                    end
                end
                StSweep: begin
                    if (rd_valid) begin
                        if (rd_last) begin
                            drain_q <= '0;
                            state_q <= StDrain;
                        end else begin
                            rd_addr_q <= rd_addr_q + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (drain_end) begin
                        if (full_q) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            state_q <= StWaitDig;
                        end
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    online_div_valid_pipe #(
        .DEPTH (RD_LAT)
    ) u_valid_pipe (
        .clk         (clk),
        .async_clear (async_clear),
        .din         (rd_valid),
        .dout        (rd_data_valid)
    );

`ifdef ONLINE_DIV_STALL_CNT_EN
    always_ff @(posedge clk or negedge async_clear) begin
        if (!async_clear) begin
            stall_cnt <= '0;
        end else if (start_ok && !abort) begin
            stall_cnt <= '0;
        end else if (((state_q == StSweep) && rd_stall) || (dig_ready && !dig_valid)) begin
            if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_online_div_ca_seq_ctrl.sv
// Directed bench for online_div_ca_seq_ctrl: one instance with RD_LAT=1, one with RD_LAT=3.
module tb_online_div_ca_seq_ctrl;

    localparam int unsigned AW = 7;

    logic clk = 1'b0;
    logic async_clear, start, abort, dig_valid, rd_stall;

    logic          dig_ready_1, wr_enable_1, enable_all_1, rd_valid_1, rd_last_1;
    logic          rd_data_valid_1, iter_done_1, busy_1, done_1;
    logic [AW+1:0] master_cnt_1;
    logic [AW-1:0] rd_addr_1, comp_cycle_1;

    logic          dig_ready_3, wr_enable_3, enable_all_3, rd_valid_3, rd_last_3;
    logic          rd_data_valid_3, iter_done_3, busy_3, done_3;
    logic [AW+1:0] master_cnt_3;
    logic [AW-1:0] rd_addr_3, comp_cycle_3;

`ifdef ONLINE_DIV_STALL_CNT_EN
    logic [15:0] stall_cnt_1, stall_cnt_3;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [2:0]  hist;

    always #5 clk = ~clk;

    online_div_ca_seq_ctrl #(
        .RAM_ADDR_WIDTH (AW),
        .N_DIGITS       (8),
        .RD_LAT         (1)
    ) dut_1 (
        .clk           (clk),
        .async_clear   (async_clear),
        .start         (start),
        .abort         (abort),
        .dig_valid     (dig_valid),
        .dig_ready     (dig_ready_1),
        .rd_stall      (rd_stall),
        .master_cnt    (master_cnt_1),
        .wr_enable     (wr_enable_1),
        .enable_all    (enable_all_1),
        .rd_addr       (rd_addr_1),
        .comp_cycle    (comp_cycle_1),
        .rd_valid      (rd_valid_1),
        .rd_last       (rd_last_1),
        .rd_data_valid (rd_data_valid_1),
        .iter_done     (iter_done_1),
        .busy          (busy_1),
        .done          (done_1)
`ifdef ONLINE_DIV_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt_1)
`endif
    );

    online_div_ca_seq_ctrl #(
        .RAM_ADDR_WIDTH (AW),
        .N_DIGITS       (8),
        .RD_LAT         (3)
    ) dut_3 (
        .clk           (clk),
        .async_clear   (async_clear),
        .start         (start),
        .abort         (abort),
        .dig_valid     (dig_valid),
        .dig_ready     (dig_ready_3),
        .rd_stall      (rd_stall),
        .master_cnt    (master_cnt_3),
        .wr_enable     (wr_enable_3),
        .enable_all    (enable_all_3),
        .rd_addr       (rd_addr_3),
        .comp_cycle    (comp_cycle_3),
        .rd_valid      (rd_valid_3),
        .rd_last       (rd_last_3),
        .rd_data_valid (rd_data_valid_3),
        .iter_done     (iter_done_3),
        .busy          (busy_3),
        .done          (done_3)
`ifdef ONLINE_DIV_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt_3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One RD_LAT=1 iteration j starting in WAIT_DIG: gap idle cycles, handshake,
    // stall cycles, then (j>>2)+1 reads and one drain cycle.
    task automatic do_iter(input int j, input int gap, input int stall);
        int words;
        words = (j >> 2) + 1;
        for (int g = 0; g < gap; g++) begin
            dig_valid = 1'b0;
            #1;
            check("gap_ready", dig_ready_1, 1);
            check("gap_wr", wr_enable_1, 0);
            check("gap_cnt", master_cnt_1, j);
            step();
        end
        dig_valid = 1'b1;
        #1;
        check("hs_wr", wr_enable_1, 1);
        check("hs_cnt", master_cnt_1, j);
        step();
        dig_valid = 1'b0;
        for (int s = 0; s < stall; s++) begin
            rd_stall = 1'b1;
            #1;
            check("stall_rv", rd_valid_1, 0);
            check("stall_addr", rd_addr_1, 0);
            check("stall_idone", iter_done_1, 0);
            step();
        end
        rd_stall = 1'b0;
        for (int w = 0; w < words; w++) begin
            #1;
            check("sw_rv", rd_valid_1, 1);
            check("sw_addr", rd_addr_1, w);
            check("sw_last", rd_last_1, (w == words - 1) ? 1 : 0);
            check("sw_idone", iter_done_1, 0);
            step();
        end
        #1;
        check("dr_idone", iter_done_1, 1);
        check("dr_comp", comp_cycle_1, j >> 2);
        check("dr_rdv", rd_data_valid_1, 1);
        check("dr_rv", rd_valid_1, 0);
        step();
    endtask

    // One cycle of the RD_LAT=3 instance; rd_data_valid must echo the expected
    // rd_valid from three cycles earlier.
    task automatic cyc3(input logic e_wr, input logic e_rv, input logic e_last,
                        input logic e_idone, input int e_addr);
        #1;
        check("l3_wr", wr_enable_3, e_wr);
        check("l3_rv", rd_valid_3, e_rv);
        check("l3_last", rd_last_3, e_last);
        check("l3_idone", iter_done_3, e_idone);
        check("l3_rdv", rd_data_valid_3, hist[2]);
        if (e_rv) check("l3_addr", rd_addr_3, e_addr);
        hist = {hist[1:0], e_rv};
        step();
    endtask

    initial begin
        async_clear = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        dig_valid   = 1'b0;
        rd_stall    = 1'b0;
        hist        = 3'b000;

        #23;
        check("rst_busy", busy_1, 0);
        check("rst_done", done_1, 0);
        check("rst_en", enable_all_1, 0);
        check("rst_cnt", master_cnt_1, 0);
        check("rst_ready", dig_ready_1, 0);
        check("rst_rdv", rd_data_valid_1, 0);
        check("rst_idone", iter_done_1, 0);
        step();
        async_clear = 1'b1;
        step();

        // Full division with a 5-cycle digit gap in iteration 2 and a 3-cycle stall in 4.
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        check("wd_en", enable_all_1, 1);
        check("wd_busy", busy_1, 1);
        for (int j = 0; j < 8; j++) do_iter(j, (j == 2) ? 5 : 0, (j == 4) ? 3 : 0);
        dig_valid = 1'b1;
        #1;
        check("dn_done", done_1, 1);
        check("dn_cnt", master_cnt_1, 8);
        check("dn_busy", busy_1, 0);
        check("dn_wr", wr_enable_1, 0);
        check("dn_ready", dig_ready_1, 0);
        step();
        check("dn_hold", done_1, 1);
        check("dn_hold_cnt", master_cnt_1, 8);
        dig_valid = 1'b0;

        // Restart from DONE, then abort on the handshake at master_cnt=3.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 0; j < 3; j++) do_iter(j, 0, 0);
        dig_valid = 1'b1;
        abort     = 1'b1;
        #1;
        check("ab_wr", wr_enable_1, 0);
        check("ab_cnt_pre", master_cnt_1, 3);
        step();
        abort     = 1'b0;
        dig_valid = 1'b0;
        #1;
        check("ab_busy", busy_1, 0);
        check("ab_cnt", master_cnt_1, 0);
        check("ab_en", enable_all_1, 0);
        check("ab_done", done_1, 0);
        step();

        // Async clear in the SWEEP of iteration 6 with rd_addr=1.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 0; j < 6; j++) do_iter(j, 0, 0);
        dig_valid = 1'b1;
        #1;
        check("ac_hs", wr_enable_1, 1);
        step();
        dig_valid = 1'b0;
        #1;
        check("ac_addr0", rd_addr_1, 0);
        step();
        #1;
        check("ac_addr1", rd_addr_1, 1);
        check("ac_rv", rd_valid_1, 1);
        async_clear = 1'b0;
        #1;
        check("ac_cnt", master_cnt_1, 0);
        check("ac_addr", rd_addr_1, 0);
        check("ac_comp", comp_cycle_1, 0);
        check("ac_rv0", rd_valid_1, 0);
        check("ac_busy", busy_1, 0);
        check("ac_en", enable_all_1, 0);
        check("ac_rdv", rd_data_valid_1, 0);
        step();
        async_clear = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        do_iter(0, 0, 0);

        // RD_LAT=3 instance with digits back-to-back.
        async_clear = 1'b0;
        #2;
        async_clear = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        dig_valid = 1'b1;
        hist = 3'b000;
        for (int j = 0; j < 8; j++) begin
            #1;
            check("l3_cnt", master_cnt_3, j);
            cyc3(1'b1, 1'b0, 1'b0, 1'b0, 0);
            for (int w = 0; w <= (j >> 2); w++)
                cyc3(1'b0, 1'b1, (w == (j >> 2)), 1'b0, w);
            for (int d = 0; d < 3; d++)
                cyc3(1'b0, 1'b0, 1'b0, (d == 2), 0);
        end
        #1;
        check("l3_done", done_3, 1);
        check("l3_dcnt", master_cnt_3, 8);
        check("l3_dwr", wr_enable_3, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        check("l3_rs_busy", busy_3, 1);
        check("l3_rs_cnt", master_cnt_3, 0);
        check("l3_rs_done", done_3, 0);
        check("l3_rs_wr", wr_enable_3, 1);
        step();
        dig_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
